// File: rtl/spi_ram_arbiter_pkg.sv
// spi_ram_pkg: shared constants and types for the SPI/host RAM arbiter.
// Command opcodes carried in rx_data[9:8], FSM state encoding and the
// SPI payload width.
package spi_ram_pkg;

    localparam int PAYLOAD_W = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Grant vector bit positions
    localparam int GNT_SPI  = 0;
    localparam int GNT_HOST = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_CAPT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_ram_arbiter_rr_arbiter_2.sv
// rr_arbiter_2: two-requester arbiter, bit 0 = SPI, bit 1 = host.
// Round-robin with a registered "host goes first on a tie" pointer that
// starts out favouring SPI. With SPI_PRIORITY_EN defined, SPI always wins
// a tie and no pointer exists.
// Grant is combinational and one-hot; the pointer advances only when
// 'advance' is high and something is granted.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

`ifdef SPI_PRIORITY_EN

    // Fixed priority: SPI first, host only when SPI is not asking
    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

`else

    logic host_first_q;

    // Round-robin pick: on a tie the side not granted last wins
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = host_first_q ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    // Pointer update: after an SPI grant the host gets the next tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_first_q <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            host_first_q <= gnt[0];
        end
    end

`endif

endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: decodes the SPI slave command stream into RAM accesses
// and shares a single-port RAM with a local host port. One access at a
// time; read data returns to whichever side owned the access.
// Optional build macro: SPI_PRIORITY_EN (SPI always wins ties).
//
// Handshakes: a SPI command is taken on the rising edge of rx_valid.
// The host holds host_req (with stable host_we/host_addr/host_wdata) until
// it sees the one-cycle host_gnt pulse; read data arrives with the
// one-cycle host_rvalid pulse the cycle after host_gnt. tx_valid is a
// level that stays high until the next SPI command is captured.
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  spi_ovf,
    output logic                  busy,
    output state_t                state_dbg
);

    state_t state_q, state_d;

    // SPI command capture
    logic                  rx_valid_q;
    logic                  cap;
    logic [1:0]            cmd_op;
    logic [PAYLOAD_W-1:0]  payload;

    // SPI register file and pending request
    logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
    logic                  spi_pend_q, spi_we_q, spi_ovf_q;
    logic [ADDR_WIDTH-1:0] spi_addr_q;
    logic [DATA_WIDTH-1:0] spi_data_q;

    // Access in flight (latched at grant)
    logic                  acc_host_q, acc_we_q;
    logic [ADDR_WIDTH-1:0] acc_addr_q;
    logic [DATA_WIDTH-1:0] acc_data_q;

    // Read-back registers
    logic [7:0]            tx_data_q;
    logic                  tx_valid_q;
    logic [DATA_WIDTH-1:0] host_rdata_q;

    logic [1:0]            arb_req, arb_gnt;
    logic                  in_idle;

    assign cap     = rx_valid & ~rx_valid_q;
    assign cmd_op  = rx_data[9:8];
    assign payload = rx_data[PAYLOAD_W-1:0];
    assign in_idle = (state_q == IDLE);
    assign arb_req = in_idle ? {host_req, spi_pend_q} : 2'b00;

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (in_idle),
        .gnt     (arb_gnt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_d     = state_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        host_gnt    = 1'b0;
        host_rvalid = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ram_we   = acc_we_q;
                ram_re   = ~acc_we_q;
                host_gnt = acc_host_q;
                state_d  = acc_we_q ? IDLE : RD_CAPT;
            end
            RD_CAPT: begin
                host_rvalid = acc_host_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the winner's access; ram_din keeps the last write data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_host_q <= 1'b0;
            acc_we_q   <= 1'b0;
            acc_addr_q <= '0;
            acc_data_q <= '0;
        end else if (in_idle && (arb_gnt != 2'b00)) begin
            acc_host_q <= arb_gnt[GNT_HOST];
            if (arb_gnt[GNT_HOST]) begin
                acc_we_q   <= host_we;
                acc_addr_q <= host_addr;
                if (host_we) acc_data_q <= host_wdata;
            end else begin
                acc_we_q   <= spi_we_q;
                acc_addr_q <= spi_addr_q;
                if (spi_we_q) acc_data_q <= spi_data_q;
            end
        end
    end

    // SPI command decode, pending request and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            spi_pend_q <= 1'b0;
            spi_we_q   <= 1'b0;
            spi_addr_q <= '0;
            spi_data_q <= '0;
            spi_ovf_q  <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            if ((state_q == ACCESS) && !acc_host_q) begin
                spi_pend_q <= 1'b0;
            end
            if (cap) begin
                case (cmd_op)
                    CMD_WR_ADDR: wr_addr_q <= payload;
                    CMD_RD_ADDR: rd_addr_q <= payload;
                    default: begin
                        // A data command while one is still queued is lost
                        if (spi_pend_q) begin
                            spi_ovf_q <= 1'b1;
                        end else begin
                            spi_pend_q <= 1'b1;
                            spi_we_q   <= (cmd_op == CMD_WR_DATA);
                            spi_addr_q <= (cmd_op == CMD_WR_DATA) ? wr_addr_q : rd_addr_q;
                            if (cmd_op == CMD_WR_DATA) spi_data_q <= payload;
                        end
                    end
                endcase
            end
        end
    end

    // Read data return: SPI gets a held level, host a latched copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            if (cap) begin
                tx_valid_q <= 1'b0;
            end
            if (state_q == RD_CAPT) begin
                if (acc_host_q) begin
                    host_rdata_q <= ram_dout;
                end else begin
                    tx_data_q  <= ram_dout;
                    tx_valid_q <= 1'b1;
                end
            end
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign host_rdata = host_rvalid ? ram_dout : host_rdata_q;
    assign ram_addr   = acc_addr_q;
    assign ram_din    = acc_data_q;
    assign spi_ovf    = spi_ovf_q;
    assign busy       = ~in_idle;
    assign state_dbg  = state_q;

endmodule
